// File: rtl/gf16_pkg.sv
// GF(16) arithmetic helpers shared by the syndrome calculator.
// Field: primitive polynomial x^4+x+1, alpha = 4'b0010.
// Optional build macro used by the top level: GF16_SYN_LAST_CHECK_EN.
package gf16_pkg;

   // Primitive polynomial x^4 + x + 1
   localparam logic [4:0] GF16_POLY = 5'b10011;

   // Field element in polynomial basis
   typedef logic [3:0] gf16_t;

   // Handshake states of the syndrome block
   typedef enum logic {
      ST_ACC  = 1'b0,
      ST_HOLD = 1'b1
   } syn_state_e;

   // Shift-and-add multiply with reduction by GF16_POLY; XOR/AND only.
   function automatic gf16_t gf16_mul(input gf16_t a, input gf16_t b);
      gf16_t prod;
      gf16_t shf;
      prod = '0;
      shf  = a;
      for (int i = 0; i < 4; i++) begin
         if (b[i]) begin
            prod = prod ^ shf;
         end
         shf = {shf[2:0], 1'b0} ^ (shf[3] ? GF16_POLY[3:0] : 4'b0000);
      end
      return prod;
   endfunction

   // alpha^e for any integer e; the multiplicative group has order 15.
   // Used only at elaboration to build root constants.
   function automatic gf16_t gf16_alpha_pow(input int e);
      int    m;
      gf16_t r;
      m = e % 15;
      if (m < 0) begin
         m = m + 15;
      end
      r = 4'b0001;
      for (int i = 0; i < 15; i++) begin
         if (i < m) begin
            r = gf16_mul(r, 4'b0010);
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/gf16_horner_cell.sv
// One Horner accumulator for a single syndrome S_j = r(root).
// load restarts the polynomial with the current symbol; otherwise the
// accumulator is multiplied by the root and the symbol is added.
module gf16_horner_cell
   import gf16_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic [3:0]  root,
   input  logic        load,
   input  logic        enable,
   input  logic [3:0]  symbol,
   output logic [3:0]  acc,
   output logic [3:0]  acc_next
);

   gf16_t acc_q;
   gf16_t acc_d;
   gf16_t horner_val;

   // Next accumulator value: fresh load or one Horner step
   always_comb begin
      horner_val = gf16_mul(acc_q, root) ^ symbol;
      acc_d      = acc_q;
      if (enable) begin
         acc_d = load ? symbol : horner_val;
      end
   end

   // Accumulator register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

   assign acc      = acc_q;
   assign acc_next = acc_d;

endmodule

// File: rtl/gf16_syndrome.sv
// Streaming Reed-Solomon syndrome calculator over GF(16).
// Symbols arrive highest degree first; NROOTS syndromes are produced by
// Horner accumulation and held as one word until the consumer takes it.
// Optional build macro: GF16_SYN_LAST_CHECK_EN enables in_last checking
// and the len_err flag; without it in_last is ignored and len_err is 0.
// reset_n asserts asynchronously; its release is expected to be already
// synchronised to clk by the surrounding reset controller.
module gf16_syndrome
   import gf16_pkg::*;
#(
   parameter int NSYM   = 15,
   parameter int NROOTS = 4,
   parameter int FCR    = 1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [3:0]            in_data,
   input  logic                  in_last,
   output logic                  syn_valid,
   input  logic                  syn_ready,
   output logic [4*NROOTS-1:0]   syn,
   output logic                  syn_nonzero,
   output logic                  len_err
);

   localparam int CNT_W = (NSYM > 1) ? $clog2(NSYM) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSYM - 1);

   syn_state_e         state_q;
   syn_state_e         state_d;
   logic [CNT_W-1:0]   count_q;
   logic [CNT_W-1:0]   count_d;
   logic               in_ready_q;
   logic               in_ready_d;
   logic               syn_valid_q;
   logic               syn_valid_d;
   logic               syn_nonzero_q;
   logic               syn_nonzero_d;
   logic               len_err_q;
   logic               len_err_d;

   logic               in_hs;
   logic               first_sym;
   logic               last_sym;
   logic [4*NROOTS-1:0] acc_flat;
   logic [4*NROOTS-1:0] acc_next_flat;

   // in_ready is only high in ACC, so a handshake implies ACC
   assign in_hs     = in_valid & in_ready_q;
   assign first_sym = in_hs & (count_q == '0);
   assign last_sym  = in_hs & (count_q == LAST_CNT);

   // One Horner cell per root alpha^(FCR+j-1), j = gi+1
   generate
      for (genvar gi = 0; gi < NROOTS; gi++) begin : g_root
         localparam gf16_t ROOT = gf16_alpha_pow(FCR + gi);

         gf16_horner_cell u_cell (
            .clk      (clk),
            .reset_n  (reset_n),
            .root     (ROOT),
            .load     (first_sym),
            .enable   (in_hs),
            .symbol   (in_data),
            .acc      (acc_flat[4*gi +: 4]),
            .acc_next (acc_next_flat[4*gi +: 4])
         );
      end
   endgenerate

   // Handshake FSM, symbol counter and result flags (next-state logic)
   always_comb begin
      state_d       = state_q;
      count_d       = count_q;
      in_ready_d    = in_ready_q;
      syn_valid_d   = syn_valid_q;
      syn_nonzero_d = syn_nonzero_q;
      len_err_d     = len_err_q;

      case (state_q)
         ST_ACC: begin
            if (in_hs) begin
               count_d = count_q + CNT_W'(1);
`ifdef GF16_SYN_LAST_CHECK_EN
               // Marker must be set exactly on the counted final symbol;
               // the flag restarts with each new block.
               len_err_d = (first_sym ? 1'b0 : len_err_q) |
                           (in_last ^ (count_q == LAST_CNT));
`endif
               if (last_sym) begin
                  state_d       = ST_HOLD;
                  in_ready_d    = 1'b0;
                  syn_valid_d   = 1'b1;
                  // Flag comes from the values being loaded so it lines
                  // up with syn in the first HOLD cycle.
                  syn_nonzero_d = |acc_next_flat;
               end
            end
         end
         ST_HOLD: begin
            if (syn_ready) begin
               state_d     = ST_ACC;
               count_d     = '0;
               in_ready_d  = 1'b1;
               syn_valid_d = 1'b0;
            end
         end
         default: begin
            state_d     = ST_ACC;
            count_d     = '0;
            in_ready_d  = 1'b1;
            syn_valid_d = 1'b0;
         end
      endcase
   end

   // FSM and control registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= ST_ACC;
         count_q       <= '0;
         in_ready_q    <= 1'b1;
         syn_valid_q   <= 1'b0;
         syn_nonzero_q <= 1'b0;
         len_err_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         count_q       <= count_d;
         in_ready_q    <= in_ready_d;
         syn_valid_q   <= syn_valid_d;
         syn_nonzero_q <= syn_nonzero_d;
         len_err_q     <= len_err_d;
      end
   end

`ifndef GF16_SYN_LAST_CHECK_EN
   // Marker is deliberately not consumed in this build
   logic unused_in_last;
   assign unused_in_last = in_last;
`endif

   assign in_ready    = in_ready_q;
   assign syn_valid   = syn_valid_q;
   assign syn         = acc_flat;
   assign syn_nonzero = syn_nonzero_q;
   assign len_err     = len_err_q;

endmodule

// File: tb/tb_gf16_syndrome.sv
// Directed testbench for gf16_syndrome (NSYM=15, NROOTS=4, FCR=1).
// Expected syndromes are hand-computed constants.
module tb_gf16_syndrome;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_data;
   logic        in_last;
   logic        syn_valid;
   logic        syn_ready;
   logic [15:0] syn;
   logic        syn_nonzero;
   logic        len_err;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   gf16_syndrome #(.NSYM(15), .NROOTS(4), .FCR(1)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .in_last     (in_last),
      .syn_valid   (syn_valid),
      .syn_ready   (syn_ready),
      .syn         (syn),
      .syn_nonzero (syn_nonzero),
      .len_err     (len_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer one symbol and hold it until accepted (bounded wait)
   task automatic send_sym(input logic [3:0] d, input logic last);
      int guard;
      guard    = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      while (!in_ready && guard < 50) begin
         tick();
         guard++;
      end
      if (!in_ready) begin
         chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
      end
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_data  = 4'($urandom);
   endtask

   // Send 15 symbols; symbol i (i=0 highest degree) at blk[4i+:4]
   task automatic send_block(input logic [59:0] blk, input bit gaps, input int last_idx);
      for (int i = 0; i < 15; i++) begin
         if (gaps) begin
            int g;
            g = $urandom_range(0, 2);
            for (int k = 0; k < g; k++) begin
               in_valid = 1'b0;
               in_data  = 4'($urandom);
               in_last  = 1'($urandom);
               tick();
            end
            in_last = 1'b0;
         end
         if (i == 14) begin
            chk("valid_early", {31'd0, syn_valid}, 32'd0);
         end
         send_sym(blk[4*i +: 4], i == last_idx);
      end
   endtask

   // Check result word right after the last accept, apply backpressure, consume
   task automatic expect_syn(input string tag, input logic [15:0] exp_syn,
                             input logic exp_nz, input logic exp_le, input int hold);
      $display("block %s: syn=%h nz=%0d len_err=%0d (exp %h %0d %0d)",
               tag, syn, syn_nonzero, len_err, exp_syn, exp_nz, exp_le);
      chk({tag, "_valid"},   {31'd0, syn_valid},   32'd1);
      chk({tag, "_syn"},     {16'd0, syn},         {16'd0, exp_syn});
      chk({tag, "_nz"},      {31'd0, syn_nonzero}, {31'd0, exp_nz});
      chk({tag, "_len_err"}, {31'd0, len_err},     {31'd0, exp_le});
      chk({tag, "_rdy_low"}, {31'd0, in_ready},    32'd0);
      for (int c = 0; c < hold; c++) begin
         tick();
         chk({tag, "_hold_syn"},   {16'd0, syn},         {16'd0, exp_syn});
         chk({tag, "_hold_valid"}, {31'd0, syn_valid},   32'd1);
         chk({tag, "_hold_rdy"},   {31'd0, in_ready},    32'd0);
         chk({tag, "_hold_nz"},    {31'd0, syn_nonzero}, {31'd0, exp_nz});
      end
      syn_ready = 1'b1;
      tick();
      syn_ready = 1'b0;
      chk({tag, "_drop_valid"}, {31'd0, syn_valid}, 32'd0);
      chk({tag, "_bubble_rdy"}, {31'd0, in_ready},  32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [59:0] blk_zero;
      logic [59:0] blk_last1;
      logic [59:0] blk_first1;
      logic [59:0] blk_deg1;
      logic [59:0] blk_both;

      blk_zero   = '0;
      blk_last1  = 60'd1 << (4 * 14);
      blk_first1 = 60'd1;
      blk_deg1   = 60'd1 << (4 * 13);
      blk_both   = blk_first1 | blk_last1;

      reset_n   = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_last   = 1'b0;
      syn_ready = 1'b0;
      tick();
      tick();
      chk("rst_valid",   {31'd0, syn_valid},   32'd0);
      chk("rst_ready",   {31'd0, in_ready},    32'd1);
      chk("rst_syn",     {16'd0, syn},         32'd0);
      chk("rst_nz",      {31'd0, syn_nonzero}, 32'd0);
      chk("rst_len_err", {31'd0, len_err},     32'd0);
      reset_n = 1'b1;
      tick();

      // All-zero codeword
      send_block(blk_zero, 1'b0, 14);
      expect_syn("zero", 16'h0000, 1'b0, 1'b0, 0);

      // Only final symbol = 1 -> every syndrome is 1
      send_block(blk_last1, 1'b0, 14);
      expect_syn("last1", 16'h1111, 1'b1, 1'b0, 0);

      // Only degree-14 symbol = 1, with 5 cycles of backpressure
      send_block(blk_first1, 1'b0, 14);
      expect_syn("first1", 16'hEFD9, 1'b1, 1'b0, 5);

      // Degree-1 term only: alpha^1..alpha^4 = 2,4,8,3; starts right after bubble
      send_block(blk_deg1, 1'b0, 14);
      expect_syn("deg1", 16'h3842, 1'b1, 1'b0, 0);

      // First and last = 1, gap-free then with random valid gaps
      send_block(blk_both, 1'b0, 14);
      expect_syn("both", 16'hFEC8, 1'b1, 1'b0, 1);
      send_block(blk_both, 1'b1, 14);
      expect_syn("both_gaps", 16'hFEC8, 1'b1, 1'b0, 0);

      // Reset after 7 nonzero symbols
      for (int i = 0; i < 7; i++) begin
         send_sym(4'h5, 1'b0);
      end
      reset_n = 1'b0;
      #2;
      $display("reset mid-block: syn=%h valid=%0d ready=%0d", syn, syn_valid, in_ready);
      chk("mid_rst_valid", {31'd0, syn_valid},   32'd0);
      chk("mid_rst_ready", {31'd0, in_ready},    32'd1);
      chk("mid_rst_syn",   {16'd0, syn},         32'd0);
      chk("mid_rst_nz",    {31'd0, syn_nonzero}, 32'd0);
      chk("mid_rst_le",    {31'd0, len_err},     32'd0);
      tick();
      tick();
      reset_n = 1'b1;
      tick();
      send_block(blk_first1, 1'b0, 14);
      expect_syn("after_rst", 16'hEFD9, 1'b1, 1'b0, 0);

      // Misplaced in_last at symbol 7
      send_block(blk_deg1, 1'b0, 7);
`ifdef GF16_SYN_LAST_CHECK_EN
      expect_syn("bad_last", 16'h3842, 1'b1, 1'b1, 2);
`else
      expect_syn("bad_last", 16'h3842, 1'b1, 1'b0, 2);
`endif
      send_block(blk_last1, 1'b0, 14);
      expect_syn("good_last", 16'h1111, 1'b1, 1'b0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
